strip_release_unit: RTL and testbench



---
 rtl/strip_release_unit.sv | 152 +++++++++++++++
 tb/tb_strip_release_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/strip_release_unit.sv
// Strip occupancy table: applies releases and write-backs, then rescans the
// table and republishes the least-occupied strip for the placement path.
//
// state | meaning
// IDLE  | waiting; min outputs valid; accepts one write-back or release
// APPLY | subtracts the captured release width from its strip (clamped at 0)
// SCAN  | walks every strip once, keeping the lowest-index minimum
module strip_release_unit #(
  parameter int NUM_STRIPS = 16,
  parameter int IDX_W      = 4,
  parameter int STRIP_CAP  = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rel_valid,
  output logic             rel_ready,
  input  logic [IDX_W-1:0] rel_strip,
  input  logic [7:0]       rel_width,
  input  logic             occ_wr_en,
  input  logic [IDX_W-1:0] occ_wr_strip,
  input  logic [7:0]       occ_wr_width,
  output logic             min_valid,
  output logic [IDX_W-1:0] min_strip,
  output logic [7:0]       min_occupied_strip_width,
  output logic             underflow_flag,
  output logic             wr_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, APPLY, SCAN} state_t;

  localparam logic [7:0]       CAP  = 8'(STRIP_CAP);
  localparam logic [IDX_W:0]   NUM  = (IDX_W+1)'(NUM_STRIPS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STRIPS - 1);

  state_t           state, state_nxt;
  logic [7:0]       occ [NUM_STRIPS];
  logic [IDX_W-1:0] cap_strip;
  logic [7:0]       cap_width;
  logic             cap_ok;
  logic [IDX_W-1:0] scan_idx;
  logic [7:0]       run_min;
  logic [IDX_W-1:0] run_idx;

  logic             take_rel, take_wr, wr_bad;
  logic             rel_in_range, wr_in_range;
  logic [7:0]       rel_occ;
  logic [7:0]       scan_w;
  logic [7:0]       cand_min;
  logic [IDX_W-1:0] cand_idx;

  assign rel_in_range = {1'b0, rel_strip} < NUM;
  assign wr_in_range  = {1'b0, occ_wr_strip} < NUM;
  assign rel_occ      = rel_in_range ? occ[rel_strip] : 8'd0;

  assign min_valid = (state == IDLE);
  assign busy      = (state != IDLE);

  // Index 0 seeds the running minimum; later strips must be strictly smaller.
  always_comb begin
    scan_w   = occ[scan_idx];
    cand_min = run_min;
    cand_idx = run_idx;
    if ((scan_idx == '0) || (scan_w < run_min)) begin
      cand_min = scan_w;
      cand_idx = scan_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    rel_ready = 1'b0;
    take_rel  = 1'b0;
    take_wr   = 1'b0;
    wr_bad    = 1'b0;
    case (state)
      IDLE: begin
        rel_ready = !occ_wr_en;
        if (occ_wr_en) begin
          if ((occ_wr_width <= CAP) && wr_in_range) begin
            take_wr   = 1'b1;
            state_nxt = SCAN;
          end else begin
            wr_bad = 1'b1;
          end
        end else if (rel_valid) begin
          take_rel  = 1'b1;
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        wr_bad    = occ_wr_en;
        state_nxt = SCAN;
      end
      SCAN: begin
        wr_bad = occ_wr_en;
        if (scan_idx == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STRIPS; i++) occ[i] <= 8'd0;
      cap_strip                <= '0;
      cap_width                <= 8'd0;
      cap_ok                   <= 1'b0;
      scan_idx                 <= '0;
      run_min                  <= 8'd0;
      run_idx                  <= '0;
      min_strip                <= '0;
      min_occupied_strip_width <= 8'd0;
      underflow_flag           <= 1'b0;
      wr_err                   <= 1'b0;
    end else begin
      underflow_flag <= 1'b0;
      wr_err         <= wr_bad;

      if (take_wr) occ[occ_wr_strip] <= occ_wr_width;

      // Underflow is judged at capture so the pulse lines up with APPLY.
      if (take_rel) begin
        cap_strip      <= rel_strip;
        cap_width      <= rel_width;
        cap_ok         <= rel_in_range;
        underflow_flag <= rel_in_range && (rel_width > rel_occ);
      end

      if ((state == APPLY) && cap_ok)
        occ[cap_strip] <= (cap_width <= occ[cap_strip]) ? (occ[cap_strip] - cap_width) : 8'd0;

      if (state == SCAN) begin
        scan_idx <= scan_idx + IDX_W'(1);
        run_min  <= cand_min;
        run_idx  <= cand_idx;
        if (scan_idx == LAST) begin
          min_strip                <= cand_idx;
          min_occupied_strip_width <= cand_min;
        end
      end else begin
        scan_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_strip_release_unit.sv
// Bench for strip_release_unit: a table-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal results.
module tb_strip_release_unit;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rel_valid = 1'b0;
  logic       rel_ready;
  logic [3:0] rel_strip = 4'd0;
  logic [7:0] rel_width = 8'd0;
  logic       occ_wr_en = 1'b0;
  logic [3:0] occ_wr_strip = 4'd0;
  logic [7:0] occ_wr_width = 8'd0;
  logic       min_valid;
  logic [3:0] min_strip;
  logic [7:0] min_occupied_strip_width;
  logic       underflow_flag;
  logic       wr_err;
  logic       busy;

  strip_release_unit #(.NUM_STRIPS(N), .IDX_W(4), .STRIP_CAP(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .rel_valid(rel_valid), .rel_ready(rel_ready),
    .rel_strip(rel_strip), .rel_width(rel_width),
    .occ_wr_en(occ_wr_en), .occ_wr_strip(occ_wr_strip), .occ_wr_width(occ_wr_width),
    .min_valid(min_valid), .min_strip(min_strip),
    .min_occupied_strip_width(min_occupied_strip_width),
    .underflow_flag(underflow_flag), .wr_err(wr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Reference model: occupancy table plus a count of cycles left until idle.
  int m_occ [N];
  int m_left;
  bit m_uf, m_werr;
  int m_min_strip, m_min_w;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_min();
    m_min_strip = 0;
    m_min_w = m_occ[0];
    for (int i = 1; i < N; i++)
      if (m_occ[i] < m_min_w) begin
        m_min_w = m_occ[i];
        m_min_strip = i;
      end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_occ[i] = 0;
      m_left = 0; m_uf = 0; m_werr = 0; m_min_strip = 0; m_min_w = 0;
    end else begin
      m_uf = 0;
      m_werr = 0;
      if (m_left == 0) begin
        if (occ_wr_en) begin
          if (occ_wr_width > 128) m_werr = 1;
          else begin
            m_occ[occ_wr_strip] = occ_wr_width;
            m_left = N;
          end
        end else if (rel_valid) begin
          if (rel_width > m_occ[rel_strip]) begin
            m_uf = 1;
            m_occ[rel_strip] = 0;
          end else m_occ[rel_strip] = m_occ[rel_strip] - rel_width;
          m_left = N + 1;
        end
      end else begin
        m_werr = occ_wr_en;
        m_left--;
        if (m_left == 0) model_min();
      end
    end
    #2;
    if (check_en) begin
      chk("cyc_min_valid", min_valid, m_left == 0);
      chk("cyc_busy", busy, m_left != 0);
      chk("cyc_rel_ready", rel_ready, (m_left == 0) && !occ_wr_en);
      chk("cyc_underflow", underflow_flag, m_uf);
      chk("cyc_wr_err", wr_err, m_werr);
      chk("cyc_min_strip", min_strip, m_min_strip);
      chk("cyc_min_width", min_occupied_strip_width, m_min_w);
    end
  end

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!min_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(name, min_valid, 1);
  endtask

  // n = number of edges from the presenting cycle until min_valid is seen again
  task automatic wb(input int s, input int w, output int n, output bit we1);
    @(negedge clk);
    occ_wr_en = 1'b1; occ_wr_strip = 4'(s); occ_wr_width = 8'(w);
    @(negedge clk);
    occ_wr_en = 1'b0;
    n = 1;
    we1 = wr_err;
    while (!min_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wb_idle_timeout", min_valid, 1);
  endtask

  task automatic rel(input int s, input int w, output int n, output bit uf1, output bit uf2);
    int k;
    @(negedge clk);
    rel_valid = 1'b1; rel_strip = 4'(s); rel_width = 8'(w);
    #1;
    k = 0;
    while (!rel_ready && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("rel_accept_timeout", rel_ready, 1);
    @(negedge clk);
    rel_valid = 1'b0;
    n = 1;
    uf1 = underflow_flag;
    @(negedge clk);
    n = 2;
    uf2 = underflow_flag;
    while (!min_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rel_idle_timeout", min_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit we, uf1, uf2;

    // reset
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    chk("reset_min_valid", min_valid, 1);
    chk("reset_min_strip", min_strip, 0);
    chk("reset_min_width", min_occupied_strip_width, 0);
    chk("reset_busy", busy, 0);

    // write-back and its latency
    wb(3, 40, n, we);
    chk("wb_latency", n, 17);
    chk("wb_min_strip", min_strip, 0);
    chk("wb_min_width", min_occupied_strip_width, 0);

    // minimum tracking
    for (int s = 0; s < N; s++) wb(s, 50, n, we);
    wb(5, 20, n, we);
    chk("fill_min_strip", min_strip, 5);
    chk("fill_min_width", min_occupied_strip_width, 20);

    rel(5, 20, n, uf1, uf2);
    chk("rel_latency", n, 18);
    chk("rel_no_underflow", uf1, 0);
    chk("rel_min_strip", min_strip, 5);
    chk("rel_min_width", min_occupied_strip_width, 0);
    chk("model_occ5", m_occ[5], 0);

    // underflow clamp
    wb(2, 10, n, we);
    rel(2, 30, n, uf1, uf2);
    chk("uf_pulse_t1", uf1, 1);
    chk("uf_pulse_t2", uf2, 0);
    chk("uf_min_strip", min_strip, 2);
    chk("uf_min_width", min_occupied_strip_width, 0);

    // tie-break: lowest index wins
    for (int s = 0; s < N; s++) wb(s, (s == 7 || s == 9) ? 5 : 100, n, we);
    chk("tie_min_strip", min_strip, 7);
    chk("tie_min_width", min_occupied_strip_width, 5);

    // write-back beats a simultaneous release; release follows after the scan
    @(negedge clk);
    rel_valid = 1'b1; rel_strip = 4'd9; rel_width = 8'd5;
    occ_wr_en = 1'b1; occ_wr_strip = 4'd7; occ_wr_width = 8'd3;
    #1 chk("collide_rel_ready", rel_ready, 0);
    @(negedge clk);
    occ_wr_en = 1'b0;
    chk("collide_busy", busy, 1);
    rel(9, 5, n, uf1, uf2);
    chk("collide_min_strip", min_strip, 9);
    chk("collide_min_width", min_occupied_strip_width, 0);

    // write-back during SCAN is dropped with wr_err
    @(negedge clk);
    occ_wr_en = 1'b1; occ_wr_strip = 4'd4; occ_wr_width = 8'd1;
    @(negedge clk);
    occ_wr_en = 1'b0;
    @(negedge clk);
    occ_wr_en = 1'b1; occ_wr_strip = 4'd0; occ_wr_width = 8'd0;
    @(negedge clk);
    occ_wr_en = 1'b0;
    chk("scan_wr_err", wr_err, 1);
    wait_idle("scan_wr_idle_timeout");
    chk("scan_wr_min_strip", min_strip, 9);
    chk("scan_wr_min_width", min_occupied_strip_width, 0);

    // capacity boundary
    wb(0, 129, n, we);
    chk("cap129_wr_err", we, 1);
    chk("cap129_no_scan", n, 1);
    wb(0, 128, n, we);
    chk("cap128_wr_err", we, 0);
    chk("cap128_latency", n, 17);
    chk("cap128_min_strip", min_strip, 9);

    // reset during the 5th scan cycle
    @(negedge clk);
    occ_wr_en = 1'b1; occ_wr_strip = 4'd1; occ_wr_width = 8'd7;
    @(negedge clk);
    occ_wr_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("midscan_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midscan_min_valid", min_valid, 1);
    chk("midscan_busy_after", busy, 0);
    chk("midscan_min_strip", min_strip, 0);
    chk("midscan_min_width", min_occupied_strip_width, 0);
    wb(0, 60, n, we);
    chk("post_reset_latency", n, 17);
    chk("post_reset_min_strip", min_strip, 1);
    chk("post_reset_min_width", min_occupied_strip_width, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
